audio_mixer_fade_sequencer: RTL and testbench

//  Sample-rate sequencer and register scheduler for the 6-channel filter/mixer. Outputs:
//  - the mixer's clk_en sample strobe;
//  - all writes to the mixer's control registers (c_addr/c_wr/c_din).

---
 rtl/audio_mixer_fade_sequencer.sv | 151 +++++++++++++++
 tb/tb_audio_mixer_fade_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer_fade_sequencer.sv
// Sample-rate sequencer for the 6-channel mixer. Generates the sample strobe and schedules
// every mixer register write, fading volume regs toward their targets once per sample.
module audio_mixer_fade_sequencer #(
   parameter int         CLK_DIV       = 1042,
   parameter int         FADE_STEP     = 1,
   parameter logic [7:0] RST_REGS [10] = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64,
                                           8'd128, 8'd0, 8'd25, 8'd128}
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] h_addr,
   input  logic       h_wr,
   input  logic [7:0] h_din,
   output logic [7:0] h_dout,
   input  logic       mute,
   output logic       clk_en,
   output logic [3:0] c_addr,
   output logic       c_wr,
   output logic [7:0] c_din,
   output logic       ramp_active
);
   localparam int WIN = 32;
   localparam int CW  = $clog2(CLK_DIV);

   typedef enum logic {S_WAIT, S_SCAN} state_t;

   state_t        state_q;
   logic [3:0]    k_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    tgt_q [10];
   logic [7:0]    tgt_d [10];
   logic [7:0]    cur_q [7];
   logic [7:0]    cur_d [7];
   logic [2:0]    pend_q, pend_d;
   logic          clk_en_q, c_wr_q, c_wr_d, ramp_q, ramp_d, mute_q;
   logic [3:0]    c_addr_q, c_addr_d;
   logic [7:0]    c_din_q, c_din_d, h_dout_q, h_dout_d;
   logic [7:0]    cur_s, et_s, nxt;
   logic [8:0]    diff, stp, sum;
   logic          up, slot_v, any_ramp;

   always_comb begin
      cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + CW'(1);
      slot_v = (state_q == S_SCAN);

      // Volume slot: effective target, mute forces master volume toward zero
      cur_s = '0;
      et_s  = '0;
      for (int i = 0; i < 7; i++)
         if (k_q == 4'(i)) begin
            cur_s = cur_q[i];
            et_s  = tgt_q[i];
         end
      if (k_q == 4'd6 && mute) et_s = '0;

      up   = (et_s > cur_s);
      diff = up ? ({1'b0, et_s} - {1'b0, cur_s}) : ({1'b0, cur_s} - {1'b0, et_s});
      stp  = (diff < 9'(FADE_STEP)) ? diff : 9'(FADE_STEP);
      sum  = up ? ({1'b0, cur_s} + stp) : ({1'b0, cur_s} - stp);
      nxt  = sum[8] ? (up ? 8'hFF : 8'h00) : sum[7:0];

      tgt_d    = tgt_q;
      cur_d    = cur_q;
      pend_d   = pend_q;
      c_wr_d   = 1'b0;
      c_addr_d = c_addr_q;
      c_din_d  = c_din_q;

      if (slot_v && k_q < 4'd7) begin
         if (cur_s != et_s) begin
            for (int i = 0; i < 7; i++)
               if (k_q == 4'(i)) cur_d[i] = nxt;
            c_wr_d   = 1'b1;
            c_addr_d = k_q;
            c_din_d  = nxt;
         end
      end else if (slot_v) begin
         for (int i = 0; i < 3; i++)
            if (k_q == 4'(i + 7) && pend_q[i]) begin
               c_wr_d    = 1'b1;
               c_addr_d  = k_q;
               c_din_d   = tgt_q[i+7];
               pend_d[i] = 1'b0;
            end
      end

      // Host write lands after the slot logic so a colliding set beats the clear
      if (h_wr && h_addr <= 4'd9) begin
         tgt_d[h_addr] = h_din;
         for (int i = 0; i < 3; i++)
            if (h_addr == 4'(i + 7)) pend_d[i] = 1'b1;
      end

      h_dout_d = (h_addr <= 4'd9) ? tgt_q[h_addr] : '0;

      any_ramp = 1'b0;
      for (int i = 0; i < 7; i++)
         if (cur_d[i] != ((i == 6 && mute) ? 8'd0 : tgt_d[i])) any_ramp = 1'b1;
      ramp_d = ramp_q;
      if ((slot_v && k_q == 4'd9) || h_wr || (mute != mute_q)) ramp_d = any_ramp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         clk_en_q <= 1'b0;
         state_q  <= S_WAIT;
         k_q      <= '0;
         pend_q   <= '0;
         c_wr_q   <= 1'b0;
         c_addr_q <= '0;
         c_din_q  <= '0;
         h_dout_q <= '0;
         ramp_q   <= 1'b0;
         mute_q   <= 1'b0;
         for (int i = 0; i < 10; i++) tgt_q[i] <= RST_REGS[i];
         for (int i = 0; i < 7; i++)  cur_q[i] <= RST_REGS[i];
      end else begin
         cnt_q    <= cnt_d;
         clk_en_q <= (cnt_d == CW'(CLK_DIV - 1));
         tgt_q    <= tgt_d;
         cur_q    <= cur_d;
         pend_q   <= pend_d;
         c_wr_q   <= c_wr_d;
         c_addr_q <= c_addr_d;
         c_din_q  <= c_din_d;
         h_dout_q <= h_dout_d;
         ramp_q   <= ramp_d;
         mute_q   <= mute;
         case (state_q)
            S_WAIT:
               if (cnt_q == CW'(WIN - 1)) begin
                  state_q <= S_SCAN;
                  k_q     <= '0;
               end
            S_SCAN:
               if (k_q == 4'd9) state_q <= S_WAIT;
               else             k_q     <= k_q + 4'd1;
            default: state_q <= S_WAIT;
         endcase
      end
   end

   assign clk_en      = clk_en_q;
   assign c_wr        = c_wr_q;
   assign c_addr      = c_addr_q;
   assign c_din       = c_din_q;
   assign h_dout      = h_dout_q;
   assign ramp_active = ramp_q;

endmodule

// File: tb/tb_audio_mixer_fade_sequencer.sv
// Scoreboard bench: each host action queues the mixer writes it must cause (cycle, addr, data);
// a negedge monitor pops and compares every c_wr and checks clk_en on every cycle.
module tb_audio_mixer_fade_sequencer;
   localparam int CD  = 64;
   localparam int FS  = 4;
   localparam int WIN = 32;

   typedef struct {int cyc; int addr; int data;} wr_t;

   logic       clk = 1'b0, rst = 1'b1, h_wr = 1'b0, mute = 1'b0;
   logic [3:0] h_addr = '0;
   logic [7:0] h_din = '0;
   logic [7:0] h_dout, c_din;
   logic [3:0] c_addr;
   logic       clk_en, c_wr, ramp_active;

   int  nchk = 0, nerr = 0;
   int  gcyc = 0, bcnt = 0;
   bit  mon_en = 1'b0;
   wr_t exp_q [$];
   int  rst_regs [10] = '{64, 64, 64, 64, 64, 64, 128, 0, 25, 128};

   audio_mixer_fade_sequencer #(.CLK_DIV(CD), .FADE_STEP(FS)) dut (
      .clk(clk), .rst(rst), .h_addr(h_addr), .h_wr(h_wr), .h_din(h_din), .h_dout(h_dout),
      .mute(mute), .clk_en(clk_en), .c_addr(c_addr), .c_wr(c_wr), .c_din(c_din),
      .ramp_active(ramp_active));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      gcyc <= gcyc + 1;
      bcnt <= rst ? 0 : (bcnt + 1) % CD;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, gcyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         wr_t e;
         chk("clk_en", 32'(clk_en), 32'(bcnt == CD - 1));
         if (c_wr === 1'b1) begin
            chk("wr_window", 32'(bcnt >= WIN + 1 && bcnt <= WIN + 10), 1);
            chk("wr_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_cyc", gcyc, e.cyc);
               chk("wr_addr", 32'(c_addr), e.addr);
               chk("wr_data", 32'(c_din), e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cnt(int c);
      int n = 0;
      tick();
      while (bcnt != c && n < CD + 2) begin
         tick();
         n++;
      end
   endtask

   // Absolute cycle of the write from slot k, given a host change made in the current cycle
   function automatic int win_cyc(int k);
      int ws = gcyc - bcnt;
      return (bcnt < WIN + k) ? ws + WIN + k + 1 : ws + CD + WIN + k + 1;
   endfunction

   task automatic push_ramp(int k, int from, int to, int first);
      int v = from;
      int c = first;
      while (v != to) begin
         if (v < to) v = (v + FS > to) ? to : v + FS;
         else        v = (v - FS < to) ? to : v - FS;
         exp_q.push_back('{c, k, v});
         c += CD;
      end
   endtask

   task automatic host_wr(int a, int d);
      h_addr = 4'(a);
      h_din  = 8'(d);
      h_wr   = 1'b1;
      tick();
      h_wr   = 1'b0;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
      wait_cnt(WIN + 12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_clk_en", 32'(clk_en), 0);
      chk("rst_c_wr", 32'(c_wr), 0);
      chk("rst_c_addr", 32'(c_addr), 0);
      chk("rst_c_din", 32'(c_din), 0);
      chk("rst_h_dout", 32'(h_dout), 0);
      chk("rst_ramp", 32'(ramp_active), 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Idle: reset targets readable, strobe only, no writes
      for (int a = 0; a < 10; a++) begin
         h_addr = 4'(a);
         tick();
         chk("h_dout_rst", 32'(h_dout), rst_regs[a]);
      end
      repeat (200) tick();
      chk("idle_ramp", 32'(ramp_active), 0);

      // Ramp up reg0 64 -> 74
      wait_cnt(5);
      push_ramp(0, 64, 74, win_cyc(0));
      host_wr(0, 74);
      chk("ramp_up_act", 32'(ramp_active), 1);
      drain(6 * CD);
      chk("ramp_up_done", 32'(ramp_active), 0);

      // Ramp down reg3 64 -> 57, last step shorter than FADE_STEP
      wait_cnt(5);
      push_ramp(3, 64, 57, win_cyc(3));
      host_wr(3, 57);
      drain(6 * CD);
      chk("ramp_dn_done", 32'(ramp_active), 0);

      // Forwarded reg8, readback
      wait_cnt(5);
      exp_q.push_back('{win_cyc(8), 8, 40});
      host_wr(8, 40);
      h_addr = 4'd8;
      tick();
      chk("h_dout_r8", 32'(h_dout), 40);
      drain(3 * CD);

      // Mute ramps master volume to zero; target readback unchanged
      wait_cnt(5);
      push_ramp(6, 128, 0, win_cyc(6));
      mute = 1'b1;
      tick();
      chk("mute_act", 32'(ramp_active), 1);
      h_addr = 4'd6;
      tick();
      chk("h_dout_mute", 32'(h_dout), 128);
      drain(40 * CD);
      chk("mute_done", 32'(ramp_active), 0);
      wait_cnt(5);
      push_ramp(6, 0, 128, win_cyc(6));
      mute = 1'b0;
      drain(40 * CD);
      chk("unmute_done", 32'(ramp_active), 0);

      // Collision on slot 7: pend survives, goes out next window
      wait_cnt(WIN + 7);
      exp_q.push_back('{win_cyc(7), 7, 5});
      host_wr(7, 5);
      drain(3 * CD);

      // Collision on volume slot 1: pre-write target used this window
      wait_cnt(WIN + 1);
      push_ramp(1, 64, 66, win_cyc(1));
      host_wr(1, 66);
      drain(3 * CD);

      // Two writes in one sample: only the last value goes out
      wait_cnt(2);
      exp_q.push_back('{win_cyc(9), 9, 20});
      host_wr(9, 10);
      host_wr(9, 20);
      drain(3 * CD);

      // Out-of-range address is ignored
      host_wr(12, 99);
      h_addr = 4'd12;
      tick();
      chk("h_dout_oob", 32'(h_dout), 0);

      // Reset mid-window aborts the scan
      wait_cnt(5);
      exp_q.push_back('{win_cyc(2), 2, 68});
      host_wr(2, 80);
      host_wr(8, 7);
      wait_cnt(WIN + 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_abort_wr", 32'(c_wr), 0);
      chk("rst_abort_dout", 32'(h_dout), 0);
      repeat (3 * CD) tick();
      h_addr = 4'd2;
      tick();
      chk("h_dout_r2_rst", 32'(h_dout), 64);
      chk("rst_ramp_after", 32'(ramp_active), 0);
      chk("q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
